cdb_arbiter: RTL and testbench

- Shares the single result-broadcast bus (tag/data/rdy, the `sal_t` fields consumed by the register file and reservation stations) among N_REQ functional units.
- Each requester pushes completed results into its own small FIFO.
- A round-robin scheduler pops at most one result per cycle and drives it onto a registered broadcast bus.
- Sits between the functional units and the regfile/ROB writeback path.

---
 rtl/cdb_arbiter_pkg.sv | 23 ++
 rtl/cdb_arbiter_if.sv | 32 +++
 rtl/cdb_fifo.sv | 82 ++++++++
 rtl/cdb_arbiter.sv | 109 ++++++++++
 tb/tb_cdb_arbiter.sv | 201 ++++++++++++++++++++
 5 files changed

// File: rtl/cdb_arbiter_pkg.sv
// Shared types and widths for the result-broadcast arbiter and its per-requester FIFOs.
// Latency: none (types, constants and a pure helper function only).
// Backpressure: not applicable.
package cdb_arbiter_pkg;

    // Widths match the existing tag/data/rdy broadcast fields seen by regfile and stations.
    localparam int TAG_W     = 4;
    localparam int DATA_W    = 32;
    localparam int N_REQ_DEF = 4;
    localparam int DEPTH_DEF = 2;

    // One completed result as stored in a requester FIFO and driven on the bus.
    typedef struct packed {
        logic [TAG_W-1:0]  tag;
        logic [DATA_W-1:0] data;
    } cdb_entry_t;

    // Round-robin successor of ptr in a ring of n slots.
    function automatic int rr_inc(input int ptr, input int n);
        return (ptr + 1 >= n) ? 0 : ptr + 1;
    endfunction

endpackage

// File: rtl/cdb_arbiter_if.sv
// Requester push side plus the registered broadcast bus of the arbiter.
// Latency: wires only.
// Backpressure: req_ready per requester; the broadcast side has none.
interface cdb_arbiter_if
    import cdb_arbiter_pkg::*;
#(
    parameter int N_REQ = N_REQ_DEF
) ();

    logic [N_REQ-1:0]             req_valid;
    logic [N_REQ-1:0][TAG_W-1:0]  req_tag;
    logic [N_REQ-1:0][DATA_W-1:0] req_data;
    logic [N_REQ-1:0]             req_ready;

    logic                         cdb_rdy;
    logic [TAG_W-1:0]             cdb_tag;
    logic [DATA_W-1:0]            cdb_data;
    logic                         busy;

    // Functional-unit side: pushes results, observes the bus.
    modport master (
        output req_valid, req_tag, req_data,
        input  req_ready, cdb_rdy, cdb_tag, cdb_data, busy
    );

    // Arbiter side.
    modport slave (
        input  req_valid, req_tag, req_data,
        output req_ready, cdb_rdy, cdb_tag, cdb_data, busy
    );

endinterface

// File: rtl/cdb_fifo.sv
// Small circular FIFO holding completed results of one functional unit.
// Latency: a push is visible at head/empty after one edge; no bypass.
// Backpressure: full is driven from the registered count only; clear wins over push/pop.
module cdb_fifo
    import cdb_arbiter_pkg::*;
#(
    parameter int DEPTH = DEPTH_DEF
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       clear,
    input  logic       push,
    input  cdb_entry_t push_dat,
    input  logic       pop,
    output logic       empty,
    output logic       full,
    output cdb_entry_t head
);

    // DEPTH is a power of two, so pointer wrap is natural binary overflow.
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    cdb_entry_t      mem_q [DEPTH];
    cdb_entry_t      mem_d [DEPTH];
    logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            do_push;
    logic            do_pop;

    assign empty   = (cnt_q == '0);
    assign full    = (cnt_q == CW'(DEPTH));
    assign head    = mem_q[rd_ptr_q];
    // Guarding here makes overflow/underflow impossible regardless of the caller.
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;

    // Next-state for storage, pointers and occupancy.
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        if (clear) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            cnt_d    = '0;
        end else begin
            if (do_push) begin
                mem_d[wr_ptr_q] = push_dat;
                wr_ptr_d        = wr_ptr_q + 1'b1;
            end
            if (do_pop) begin
                rd_ptr_d = rd_ptr_q + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   cnt_d = cnt_q + 1'b1;
                2'b01:   cnt_d = cnt_q - 1'b1;
                default: cnt_d = cnt_q;
            endcase
        end
    end

    // State registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

endmodule

// File: rtl/cdb_arbiter.sv
// Round-robin share of the single result-broadcast bus among N_REQ functional units.
// Latency: push at edge E, earliest broadcast registered at edge E+1; one result per cycle total.
// Backpressure: req_ready[i] = FIFO i not full (registered); the bus is always consumed.
module cdb_arbiter
    import cdb_arbiter_pkg::*;
#(
    parameter int N_REQ = N_REQ_DEF,
    parameter int DEPTH = DEPTH_DEF
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                flush,
    cdb_arbiter_if.slave        bus
);

    localparam int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    logic [N_REQ-1:0]  fifo_empty;
    logic [N_REQ-1:0]  fifo_full;
    logic [N_REQ-1:0]  fifo_push;
    logic [N_REQ-1:0]  fifo_pop;
    cdb_entry_t        fifo_head [N_REQ];
    cdb_entry_t        push_dat  [N_REQ];

    logic [PTR_W-1:0]  rr_ptr_q, rr_ptr_d;
    logic              cdb_rdy_q, cdb_rdy_d;
    cdb_entry_t        cdb_ent_q, cdb_ent_d;

    logic              win_vld;
    logic [PTR_W-1:0]  win_idx;

    for (genvar i = 0; i < N_REQ; i++) begin : g_fifo
        assign push_dat[i]  = {bus.req_tag[i], bus.req_data[i]};
        // Pushes presented during a flush are dropped.
        assign fifo_push[i] = bus.req_valid[i] & ~fifo_full[i] & ~flush;

        cdb_fifo #(
            .DEPTH (DEPTH)
        ) u_fifo (
            .clk      (clk),
            .rst      (rst),
            .clear    (flush),
            .push     (fifo_push[i]),
            .push_dat (push_dat[i]),
            .pop      (fifo_pop[i]),
            .empty    (fifo_empty[i]),
            .full     (fifo_full[i]),
            .head     (fifo_head[i])
        );
    end

    // Ready looks at registered occupancy only, never at this cycle's pop.
    assign bus.req_ready = ~fifo_full;

    // Find-first non-empty FIFO scanning from rr_ptr upward, wrapping mod N_REQ.
    always_comb begin
        win_vld = 1'b0;
        win_idx = '0;
        for (int k = 0; k < N_REQ; k++) begin
            logic [PTR_W-1:0] cand;
            cand = PTR_W'((int'(rr_ptr_q) + k) % N_REQ);
            if (!win_vld && !fifo_empty[cand]) begin
                win_vld = 1'b1;
                win_idx = cand;
            end
        end
    end

    // One-hot pop of the winner's head; suppressed while flushing.
    always_comb begin
        fifo_pop = '0;
        for (int i = 0; i < N_REQ; i++) begin
            fifo_pop[i] = win_vld && !flush && (win_idx == PTR_W'(i));
        end
    end

    // Next broadcast and pointer; tag/data hold their last value when idle or flushing.
    always_comb begin
        rr_ptr_d  = rr_ptr_q;
        cdb_rdy_d = 1'b0;
        cdb_ent_d = cdb_ent_q;
        if (flush) begin
            rr_ptr_d = '0;
        end else if (win_vld) begin
            cdb_rdy_d = 1'b1;
            cdb_ent_d = fifo_head[win_idx];
            rr_ptr_d  = PTR_W'(rr_inc(int'(win_idx), N_REQ));
        end
    end

    // Registered broadcast bus and round-robin pointer.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rr_ptr_q  <= '0;
            cdb_rdy_q <= 1'b0;
            cdb_ent_q <= '0;
        end else begin
            rr_ptr_q  <= rr_ptr_d;
            cdb_rdy_q <= cdb_rdy_d;
            cdb_ent_q <= cdb_ent_d;
        end
    end

    assign bus.cdb_rdy  = cdb_rdy_q;
    assign bus.cdb_tag  = cdb_ent_q.tag;
    assign bus.cdb_data = cdb_ent_q.data;
    assign bus.busy     = cdb_rdy_q | ~(&fifo_empty);

endmodule

// File: tb/tb_cdb_arbiter.sv
// Directed bench for cdb_arbiter: vector table plus multi-cycle corner sequences.
// Latency: outputs are checked 1 ns after each rising edge.
// Backpressure: requesters honour req_ready; the bench always consumes the bus.
module tb_cdb_arbiter;

    localparam int N_REQ = 4;
    localparam int DEPTH = 2;

    logic clk;
    logic rst;
    logic flush;
    int   n_chk  = 0;
    int   n_fail = 0;
    logic ovf    = 1'b0;

    cdb_arbiter_if #(.N_REQ(N_REQ)) bus_if ();

    cdb_arbiter #(
        .N_REQ (N_REQ),
        .DEPTH (DEPTH)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .flush (flush),
        .bus   (bus_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // FIFO occupancy must stay within 0..DEPTH at all times.
    always @(negedge clk) begin
        if (dut.g_fifo[0].u_fifo.cnt_q > 2'd2 || dut.g_fifo[1].u_fifo.cnt_q > 2'd2 ||
            dut.g_fifo[2].u_fifo.cnt_q > 2'd2 || dut.g_fifo[3].u_fifo.cnt_q > 2'd2)
            ovf <= 1'b1;
    end

    typedef struct {
        logic        fl;
        logic [3:0]  v;
        logic [15:0] tg;   // {t3,t2,t1,t0}
        logic [31:0] b;    // data pushed by req i = b + tag_i
        logic [3:0]  e_ready;
        logic        e_rdy;
        logic [3:0]  e_tag;
        logic [31:0] e_data;
        logic        e_busy;
    } vec_t;

    vec_t vecs [20];

    function automatic vec_t mk(input logic fl, input logic [3:0] v, input logic [15:0] tg,
                                input logic [31:0] b, input logic [3:0] er, input logic erdy,
                                input logic [3:0] et, input logic [31:0] ed, input logic eb);
        vec_t r;
        r.fl = fl; r.v = v; r.tg = tg; r.b = b;
        r.e_ready = er; r.e_rdy = erdy; r.e_tag = et; r.e_data = ed; r.e_busy = eb;
        return r;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic fl, input logic [3:0] v, input logic [15:0] tg,
                         input logic [31:0] b);
        flush = fl;
        bus_if.req_valid = v;
        for (int i = 0; i < N_REQ; i++) begin
            bus_if.req_tag[i]  = tg[4*i +: 4];
            bus_if.req_data[i] = b + 32'(tg[4*i +: 4]);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_outs(input string p, input logic [3:0] er, input logic erdy,
                              input logic [3:0] et, input logic [31:0] ed, input logic eb);
        chk({p, "_ready"}, 32'(bus_if.req_ready), 32'(er));
        chk({p, "_rdy"},   32'(bus_if.cdb_rdy),   32'(erdy));
        chk({p, "_tag"},   32'(bus_if.cdb_tag),   32'(et));
        chk({p, "_data"},  bus_if.cdb_data,       ed);
        chk({p, "_busy"},  32'(bus_if.busy),      32'(eb));
    endtask

    task automatic apply(input int i);
        drive(vecs[i].fl, vecs[i].v, vecs[i].tg, vecs[i].b);
        tick();
        check_outs($sformatf("v%0d", i), vecs[i].e_ready, vecs[i].e_rdy,
                   vecs[i].e_tag, vecs[i].e_data, vecs[i].e_busy);
    endtask

    initial begin
        int          i0, i1, nb;
        logic        v0, v1, a0, a1, saw_full0;
        logic [3:0]  exp_t;

        // Single push on req 2, then rr restart via flush, 4-way burst, full FIFO 3.
        vecs[0]  = mk(0, 4'b0100, 16'h0500, 32'hDEADBEEA, 4'hF, 0, 4'h0, 32'h0,        1);
        vecs[1]  = mk(0, 4'b0000, 16'h0000, 32'h0,        4'hF, 1, 4'h5, 32'hDEADBEEF, 1);
        vecs[2]  = mk(0, 4'b0000, 16'h0000, 32'h0,        4'hF, 0, 4'h5, 32'hDEADBEEF, 0);
        vecs[3]  = mk(1, 4'b0000, 16'h0000, 32'h0,        4'hF, 0, 4'h5, 32'hDEADBEEF, 0);
        vecs[4]  = mk(0, 4'b1111, 16'h4321, 32'h10000000, 4'hF, 0, 4'h5, 32'hDEADBEEF, 1);
        vecs[5]  = mk(0, 4'b0000, 16'h0000, 32'h0,        4'hF, 1, 4'h1, 32'h10000001, 1);
        vecs[6]  = mk(0, 4'b0000, 16'h0000, 32'h0,        4'hF, 1, 4'h2, 32'h10000002, 1);
        vecs[7]  = mk(0, 4'b0000, 16'h0000, 32'h0,        4'hF, 1, 4'h3, 32'h10000003, 1);
        vecs[8]  = mk(0, 4'b0000, 16'h0000, 32'h0,        4'hF, 1, 4'h4, 32'h10000004, 1);
        vecs[9]  = mk(0, 4'b0000, 16'h0000, 32'h0,        4'hF, 0, 4'h4, 32'h10000004, 0);
        vecs[10] = mk(0, 4'b1001, 16'h7006, 32'h20000000, 4'hF, 0, 4'h4, 32'h10000004, 1);
        vecs[11] = mk(0, 4'b0000, 16'h0000, 32'h0,        4'hF, 1, 4'h6, 32'h20000006, 1);
        vecs[12] = mk(0, 4'b0000, 16'h0000, 32'h0,        4'hF, 1, 4'h7, 32'h20000007, 1);
        vecs[13] = mk(0, 4'b0000, 16'h0000, 32'h0,        4'hF, 0, 4'h7, 32'h20000007, 0);
        vecs[14] = mk(0, 4'b1001, 16'h9008, 32'h30000000, 4'hF, 0, 4'h7, 32'h20000007, 1);
        vecs[15] = mk(0, 4'b1001, 16'hB00A, 32'h30000000, 4'h7, 1, 4'h8, 32'h30000008, 1);
        vecs[16] = mk(0, 4'b1000, 16'hC000, 32'h30000000, 4'hF, 1, 4'h9, 32'h30000009, 1);
        vecs[17] = mk(0, 4'b0000, 16'h0000, 32'h0,        4'hF, 1, 4'hA, 32'h3000000A, 1);
        vecs[18] = mk(0, 4'b0000, 16'h0000, 32'h0,        4'hF, 1, 4'hB, 32'h3000000B, 1);
        vecs[19] = mk(0, 4'b0000, 16'h0000, 32'h0,        4'hF, 0, 4'hB, 32'h3000000B, 0);

        rst = 1'b0;
        drive(0, 4'b0000, 16'h0000, 32'h0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check_outs("reset", 4'hF, 0, 4'h0, 32'h0, 0);

        for (int i = 0; i < 20; i++) apply(i);

        // Req 0 streams tags 0..7, req 1 streams 8..15: grants alternate 0,1,0,1.
        i0 = 0; i1 = 0; nb = 0; saw_full0 = 1'b0;
        for (int cyc = 0; cyc < 60 && nb < 16; cyc++) begin
            v0 = (i0 < 8);
            v1 = (i1 < 8);
            a0 = v0 && bus_if.req_ready[0];
            a1 = v1 && bus_if.req_ready[1];
            if (!bus_if.req_ready[0]) saw_full0 = 1'b1;
            drive(0, {2'b00, v1, v0}, {8'h00, 4'(8 + i1), 4'(i0)}, 32'h60000000);
            tick();
            if (a0) i0++;
            if (a1) i1++;
            if (bus_if.cdb_rdy) begin
                exp_t = (nb % 2 == 0) ? 4'(nb / 2) : 4'(8 + nb / 2);
                chk($sformatf("alt%0d_tag", nb), 32'(bus_if.cdb_tag), 32'(exp_t));
                chk($sformatf("alt%0d_data", nb), bus_if.cdb_data, 32'h60000000 + 32'(exp_t));
                nb++;
            end
        end
        chk("alt_count", 32'(nb), 32'd16);
        chk("alt_req0_saw_full", 32'(saw_full0), 32'd1);
        drive(0, 4'b0000, 16'h0000, 32'h0);
        tick();
        chk("alt_idle_busy", 32'(bus_if.busy), 32'd0);

        // Flush with three entries pending and a broadcast on the bus (rr_ptr is 2 here).
        drive(0, 4'b1111, 16'h4321, 32'h40000000);
        tick();
        drive(0, 4'b0000, 16'h0000, 32'h0);
        tick();
        chk("fl_pre_rdy", 32'(bus_if.cdb_rdy), 32'd1);
        chk("fl_pre_tag", 32'(bus_if.cdb_tag), 32'd3);
        drive(1, 4'b1111, 16'hCFED, 32'h40000000);
        tick();
        chk("fl_rdy", 32'(bus_if.cdb_rdy), 32'd0);
        chk("fl_busy", 32'(bus_if.busy), 32'd0);
        chk("fl_ready", 32'(bus_if.req_ready), 32'hF);
        drive(0, 4'b0000, 16'h0000, 32'h0);
        for (int k = 0; k < 4; k++) begin
            tick();
            chk($sformatf("fl_quiet%0d_rdy", k), 32'(bus_if.cdb_rdy), 32'd0);
        end

        // Asynchronous reset mid-burst, between edges.
        drive(0, 4'b1111, 16'h8765, 32'h50000000);
        tick();
        drive(0, 4'b0000, 16'h0000, 32'h0);
        tick();
        chk("ar_pre_rdy", 32'(bus_if.cdb_rdy), 32'd1);
        chk("ar_pre_tag", 32'(bus_if.cdb_tag), 32'd5);
        #3;
        rst = 1'b0;
        #1;
        check_outs("ar_mid", 4'hF, 0, 4'h0, 32'h0, 0);
        @(negedge clk);
        rst = 1'b1;
        for (int i = 0; i < 3; i++) apply(i);

        chk("fifo_count_bound", 32'(ovf), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
